// File: rtl/tile_plotter.sv
// tile_plotter: queues packed draw commands and expands each into a TILE_W x TILE_H pixel burst
module tile_plotter #(
    parameter int TILE_W     = 1,
    parameter int TILE_H     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_init,
    input  logic        draw,
    input  logic [17:0] init_in,
    output logic [7:0]  x_out,
    output logic [6:0]  y_out,
    output logic [2:0]  colour_out,
    output logic        plot,
    output logic        busy,
    output logic        overflow,
    output logic [3:0]  fifo_count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int RW = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, PLOT} state_t;

    state_t          state, state_n;
    logic [17:0]     stage;
    logic [17:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [17:0]     push_data, head;
    logic            full, pop, accept;
    logic [CW-1:0]   col, col_n;
    logic [RW-1:0]   row, row_n;
    logic [7:0]      base_x, base_x_n, x_n;
    logic [6:0]      base_y, base_y_n, y_n;
    logic [2:0]      colour, colour_n, c_n;
    logic            plot_n, last;

    assign push_data = load_init ? init_in : stage;
    assign head      = mem[rd_ptr];
    assign full      = fifo_count == 4'(FIFO_DEPTH);
    assign pop       = state == FETCH;
    assign accept    = draw && (!full || pop);
    assign busy      = (fifo_count != 4'd0) || (state != IDLE);
    assign last      = (col == CW'(TILE_W - 1)) && (row == RW'(TILE_H - 1));

    // Staging register: holds the most recently loaded command word
    always_ff @(posedge clock) begin
        if (reset)
            stage <= '0;
        else if (load_init)
            stage <= init_in;
    end

    // FIFO storage: contents need no reset, pointers define validity
    always_ff @(posedge clock) begin
        if (accept)
            mem[wr_ptr] <= push_data;
    end

    // FIFO pointers, occupancy and sticky overflow; a full push survives only alongside a pop
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + 4'(accept) - 4'(pop);
            if (draw && !accept)
                overflow <= 1'b1;
        end
    end

    // Next-state logic: outputs are precomputed so the registered pixel lines up with the PLOT cycle
    always_comb begin
        state_n  = state;
        col_n    = col;
        row_n    = row;
        base_x_n = base_x;
        base_y_n = base_y;
        colour_n = colour;
        plot_n   = 1'b0;
        x_n      = x_out;
        y_n      = y_out;
        c_n      = colour_out;
        case (state)
            IDLE: state_n = (fifo_count != 4'd0) ? FETCH : IDLE;
            FETCH: begin
                base_x_n = head[17:10];
                base_y_n = head[9:3];
                colour_n = head[2:0];
                col_n    = '0;
                row_n    = '0;
                state_n  = PLOT;
                plot_n   = 1'b1;
                x_n      = head[17:10];
                y_n      = head[9:3];
                c_n      = head[2:0];
            end
            PLOT: begin
                if (last) begin
                    state_n = (fifo_count != 4'd0) ? FETCH : IDLE;
                end else begin
                    col_n  = (col == CW'(TILE_W - 1)) ? '0 : col + CW'(1);
                    row_n  = (col == CW'(TILE_W - 1)) ? row + RW'(1) : row;
                    plot_n = 1'b1;
                    x_n    = base_x + 8'(col_n);
                    y_n    = base_y + 7'(row_n);
                    c_n    = colour;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, scan counters, latched command and registered pixel outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            base_x     <= '0;
            base_y     <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            base_x     <= base_x_n;
            base_y     <= base_y_n;
            colour     <= colour_n;
            plot       <= plot_n;
            x_out      <= x_n;
            y_out      <= y_n;
            colour_out <= c_n;
        end
    end
endmodule

// File: tb/tb_tile_plotter.sv
// tb_tile_plotter: three tile_plotter configurations checked against a pixel-list model
module tb_tile_plotter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ld [3];
    logic        dr [3];
    logic [17:0] din [3];
    logic [7:0]  xo [3];
    logic [6:0]  yo [3];
    logic [2:0]  co [3];
    logic        pl [3];
    logic        bz [3];
    logic        ov [3];
    logic [3:0]  fc [3];

    int n_chk = 0;
    int n_fail = 0;
    int plots [3] = '{0, 0, 0};
    int max0 = 0;
    int p;
    logic [17:0] q0 [$];
    logic [17:0] q1 [$];
    logic [17:0] q2 [$];
    int ex2x [4] = '{80, 81, 80, 81};
    int ex2y [4] = '{79, 79, 80, 80};
    int ex5x [4] = '{254, 255, 254, 255};
    int ex5y [4] = '{127, 127, 0, 0};

    always #5 clock = ~clock;

    tile_plotter #(.TILE_W(1), .TILE_H(1), .FIFO_DEPTH(4)) u0 (
        .clock(clock), .reset(reset), .load_init(ld[0]), .draw(dr[0]), .init_in(din[0]),
        .x_out(xo[0]), .y_out(yo[0]), .colour_out(co[0]), .plot(pl[0]), .busy(bz[0]),
        .overflow(ov[0]), .fifo_count(fc[0]));
    tile_plotter #(.TILE_W(2), .TILE_H(2), .FIFO_DEPTH(4)) u1 (
        .clock(clock), .reset(reset), .load_init(ld[1]), .draw(dr[1]), .init_in(din[1]),
        .x_out(xo[1]), .y_out(yo[1]), .colour_out(co[1]), .plot(pl[1]), .busy(bz[1]),
        .overflow(ov[1]), .fifo_count(fc[1]));
    tile_plotter #(.TILE_W(4), .TILE_H(4), .FIFO_DEPTH(4)) u2 (
        .clock(clock), .reset(reset), .load_init(ld[2]), .draw(dr[2]), .init_in(din[2]),
        .x_out(xo[2]), .y_out(yo[2]), .colour_out(co[2]), .plot(pl[2]), .busy(bz[2]),
        .overflow(ov[2]), .fifo_count(fc[2]));

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic add_tile(input int i, input int x, input int y, input int c, input int w, input int h);
        logic [17:0] px;
        for (int r = 0; r < h; r++)
            for (int k = 0; k < w; k++) begin
                px = {8'((x + k) % 256), 7'((y + r) % 128), 3'(c)};
                case (i)
                    0: q0.push_back(px);
                    1: q1.push_back(px);
                    default: q2.push_back(px);
                endcase
            end
    endtask

    task automatic check_px(input int i);
        logic [17:0] got, exp;
        bit have;
        got  = {xo[i], yo[i], co[i]};
        have = 1'b0;
        exp  = '0;
        if (i == 0 && q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
        if (i == 1 && q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
        if (i == 2 && q2.size() > 0) begin exp = q2.pop_front(); have = 1'b1; end
        n_chk++;
        plots[i]++;
        if (!have) begin
            n_fail++;
            $display("FAIL pixel u%0d: got (%0d,%0d,c%0d), required no plot", i, got[17:10], got[9:3], got[2:0]);
        end else if (got !== exp) begin
            n_fail++;
            $display("FAIL pixel u%0d: got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)", i,
                     got[17:10], got[9:3], got[2:0], exp[17:10], exp[9:3], exp[2:0]);
        end
    endtask

    task automatic wait_plot(input int i);
        for (int k = 0; k < 40 && !pl[i]; k++)
            @(negedge clock);
        chk($sformatf("wait_plot u%0d", i), int'(pl[i]), 1);
    endtask

    // Pixel comparator: every plotted pixel must be the next one in that instance's model list
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++)
            if (pl[i])
                check_px(i);
        if (int'(fc[0]) > max0)
            max0 = int'(fc[0]);
    end

    // A reset abandons all queued and in-flight work, so the model forgets it too
    always @(posedge clock) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            ld[i] = 1'b0;
            dr[i] = 1'b0;
            din[i] = '0;
        end
        reset = 1'b1;
        repeat (2) cyc();
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset plot u%0d", i), int'(pl[i]), 0);
            chk($sformatf("reset busy u%0d", i), int'(bz[i]), 0);
            chk($sformatf("reset overflow u%0d", i), int'(ov[i]), 0);
            chk($sformatf("reset fifo_count u%0d", i), int'(fc[i]), 0);
            chk($sformatf("reset x_out u%0d", i), int'(xo[i]), 0);
        end
        cyc();
        reset = 1'b0;

        ld[0] = 1'b1; din[0] = {8'd40, 7'd40, 3'd7};
        cyc();
        ld[0] = 1'b0; dr[0] = 1'b1;
        add_tile(0, 40, 40, 7, 1, 1);
        cyc();
        dr[0] = 1'b0;
        @(negedge clock);
        chk("t1 count after push", int'(fc[0]), 1);
        chk("t1 plot after push", int'(pl[0]), 0);
        chk("t1 busy after push", int'(bz[0]), 1);
        @(negedge clock);
        chk("t1 plot in fetch", int'(pl[0]), 0);
        chk("t1 busy in fetch", int'(bz[0]), 1);
        @(negedge clock);
        chk("t1 plot", int'(pl[0]), 1);
        chk("t1 x", int'(xo[0]), 40);
        chk("t1 y", int'(yo[0]), 40);
        chk("t1 colour", int'(co[0]), 7);
        @(negedge clock);
        chk("t1 plot after", int'(pl[0]), 0);
        chk("t1 busy after", int'(bz[0]), 0);
        chk("t1 x hold", int'(xo[0]), 40);

        cyc();
        ld[1] = 1'b1; din[1] = {8'd80, 7'd79, 3'd1};
        cyc();
        ld[1] = 1'b0; dr[1] = 1'b1;
        add_tile(1, 80, 79, 1, 2, 2);
        cyc();
        dr[1] = 1'b0;
        @(negedge clock);
        chk("t2 plot after push", int'(pl[1]), 0);
        @(negedge clock);
        chk("t2 plot in fetch", int'(pl[1]), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk($sformatf("t2 plot px%0d", k), int'(pl[1]), 1);
            chk($sformatf("t2 x px%0d", k), int'(xo[1]), ex2x[k]);
            chk($sformatf("t2 y px%0d", k), int'(yo[1]), ex2y[k]);
        end
        @(negedge clock);
        chk("t2 plot after burst", int'(pl[1]), 0);

        cyc();
        ld[1] = 1'b1; dr[1] = 1'b1; din[1] = {8'd254, 7'd127, 3'd3};
        add_tile(1, 254, 127, 3, 2, 2);
        cyc();
        ld[1] = 1'b0; dr[1] = 1'b0;
        wait_plot(1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            chk($sformatf("t5 x px%0d", k), int'(xo[1]), ex5x[k]);
            chk($sformatf("t5 y px%0d", k), int'(yo[1]), ex5y[k]);
            chk($sformatf("t5 colour px%0d", k), int'(co[1]), 3);
        end
        @(negedge clock);
        chk("t5 plot after burst", int'(pl[1]), 0);

        cyc();
        max0 = 0;
        p = plots[0];
        for (int i = 0; i < 80; i++) begin
            ld[0] = 1'b1; din[0] = {8'(41 + i), 7'd40, 3'(i % 8)};
            cyc();
            ld[0] = 1'b0; dr[0] = 1'b1;
            add_tile(0, 41 + i, 40, i % 8, 1, 1);
            cyc();
            dr[0] = 1'b0;
            cyc();
        end
        repeat (10) cyc();
        chk("t3 max fifo_count", max0, 1);
        chk("t3 overflow", int'(ov[0]), 0);
        chk("t3 plots", plots[0] - p, 80);
        chk("t3 model drained", q0.size(), 0);

        p = plots[2];
        for (int i = 0; i < 6; i++) begin
            ld[2] = 1'b1; dr[2] = 1'b1; din[2] = {8'(10 * i + 3), 7'(5 * i), 3'(i)};
            if (i < 5) add_tile(2, 10 * i + 3, 5 * i, i, 4, 4);
            cyc();
        end
        ld[2] = 1'b0; dr[2] = 1'b0;
        @(negedge clock);
        chk("t4 fifo_count full", int'(fc[2]), 4);
        chk("t4 overflow set", int'(ov[2]), 1);
        for (int k = 0; k < 200 && bz[2]; k++)
            @(negedge clock);
        chk("t4 drained", int'(bz[2]), 0);
        chk("t4 overflow sticky", int'(ov[2]), 1);
        chk("t4 plots", plots[2] - p, 80);
        chk("t4 model drained", q2.size(), 0);

        cyc();
        ld[2] = 1'b1; dr[2] = 1'b1; din[2] = {8'd100, 7'd20, 3'd5};
        add_tile(2, 100, 20, 5, 4, 4);
        cyc();
        din[2] = {8'd200, 7'd60, 3'd2};
        add_tile(2, 200, 60, 2, 4, 4);
        cyc();
        ld[2] = 1'b0; dr[2] = 1'b0;
        wait_plot(2);
        repeat (5) @(negedge clock);
        chk("t6 pixel6 plot", int'(pl[2]), 1);
        chk("t6 pixel6 x", int'(xo[2]), 101);
        chk("t6 pixel6 y", int'(yo[2]), 21);
        chk("t6 fifo_count before reset", int'(fc[2]), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t6 plot after reset", int'(pl[2]), 0);
        chk("t6 fifo_count after reset", int'(fc[2]), 0);
        chk("t6 overflow after reset", int'(ov[2]), 0);
        chk("t6 busy after reset", int'(bz[2]), 0);
        p = plots[2];
        repeat (20) @(negedge clock);
        chk("t6 no further plots", plots[2] - p, 0);

        cyc();
        dr[0] = 1'b1;
        add_tile(0, 0, 0, 0, 1, 1);
        cyc();
        dr[0] = 1'b0;
        wait_plot(0);
        chk("t7 reset staging x", int'(xo[0]), 0);
        chk("t7 reset staging colour", int'(co[0]), 0);
        repeat (5) cyc();
        chk("final model u0", q0.size(), 0);
        chk("final model u1", q1.size(), 0);
        chk("final model u2", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
